// File: rtl/crtc_6845.sv
// Character-rate CRT controller (type-0 6845 style).
// CLK/RESET; CE_CHAR tick; WR/RS/DI CPU port; HSYNC/VSYNC/DE/MA/RA out.
module crtc_6845 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE_CHAR,
  input  logic        WR,
  input  logic        RS,
  input  logic [7:0]  DI,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE,
  output logic [13:0] MA,
  output logic [4:0]  RA
);

  // Register file
  logic [4:0] idx_q;
  logic [7:0] r0_q, r1_q, r2_q, r3_q;
  logic [6:0] r4_q, r6_q, r7_q;
  logic [4:0] r5_q, r9_q;
  logic [5:0] r12_q;
  logic [7:0] r13_q;

  // Counters and sync state
  logic [7:0]  hcc_q, hcc_d;
  logic [4:0]  rc_q, rc_d;
  logic [6:0]  vcc_q, vcc_d;
  logic [4:0]  adc_q, adc_d;
  logic        adj_q, adj_d;
  logic [3:0]  hsw_q, hsw_d;
  logic [3:0]  vsw_q, vsw_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [13:0] ma_row_q, ma_row_d;
  logic [13:0] ma_nxt_q, ma_nxt_d;

  // Registered outputs
  logic        de_q, de_d;
  logic [13:0] ma_q, ma_d;

  logic       line_end;
  logic       frame_end;
  logic [4:0] vs_width;

  assign line_end = (hcc_q == r0_q);
  // A zero vsync-width field means sixteen lines.
  assign vs_width = (r3_q[7:4] == 4'd0) ?
                    5'd16 : {1'b0, r3_q[7:4]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx_q <= 5'd0;
      r0_q  <= 8'd63;
      r1_q  <= 8'd40;
      r2_q  <= 8'd46;
      r3_q  <= 8'h8E;
      r4_q  <= 7'd38;
      r5_q  <= 5'd0;
      r6_q  <= 7'd25;
      r7_q  <= 7'd30;
      r9_q  <= 5'd7;
      r12_q <= 6'h30;
      r13_q <= 8'd0;
    end else if (WR) begin
      if (!RS) begin
        idx_q <= DI[4:0];
      end else begin
        case (idx_q)
          5'd0:  r0_q  <= DI;
          5'd1:  r1_q  <= DI;
          5'd2:  r2_q  <= DI;
          5'd3:  r3_q  <= DI;
          5'd4:  r4_q  <= DI[6:0];
          5'd5:  r5_q  <= DI[4:0];
          5'd6:  r6_q  <= DI[6:0];
          5'd7:  r7_q  <= DI[6:0];
          5'd9:  r9_q  <= DI[4:0];
          5'd12: r12_q <= DI[5:0];
          5'd13: r13_q <= DI;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hcc_q    <= 8'd0;
      rc_q     <= 5'd0;
      vcc_q    <= 7'd0;
      adc_q    <= 5'd0;
      adj_q    <= 1'b0;
      hsw_q    <= 4'd0;
      vsw_q    <= 4'd0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ma_row_q <= 14'd0;
      ma_nxt_q <= 14'd0;
      de_q     <= 1'b0;
      ma_q     <= 14'd0;
    end else if (CE_CHAR) begin
      hcc_q    <= hcc_d;
      rc_q     <= rc_d;
      vcc_q    <= vcc_d;
      adc_q    <= adc_d;
      adj_q    <= adj_d;
      hsw_q    <= hsw_d;
      vsw_q    <= vsw_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ma_row_q <= ma_row_d;
      ma_nxt_q <= ma_nxt_d;
      de_q     <= de_d;
      ma_q     <= ma_d;
    end
  end

  // Next state for one character tick
  always_comb begin
    hcc_d     = line_end ? 8'd0 : hcc_q + 8'd1;
    rc_d      = rc_q;
    vcc_d     = vcc_q;
    adc_d     = adc_q;
    adj_d     = adj_q;
    hsw_d     = hsw_q;
    vsw_d     = vsw_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    ma_row_d  = ma_row_q;
    ma_nxt_d  = ma_nxt_q;
    frame_end = 1'b0;

    if (hcc_q == r1_q)
      ma_nxt_d = ma_row_q + {6'd0, hcc_q};

    if (line_end) begin
      if (adj_q) begin
        adc_d = adc_q + 5'd1;
        rc_d  = rc_q + 5'd1;
        if (adc_q + 5'd1 == r5_q)
          frame_end = 1'b1;
      end else if (rc_q == r9_q) begin
        rc_d = 5'd0;
        if (vcc_q == r4_q) begin
          if (r5_q != 5'd0) begin
            // Adjust lines continue the raster count.
            adj_d = 1'b1;
            adc_d = 5'd0;
            rc_d  = r9_q + 5'd1;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          vcc_d = vcc_q + 7'd1;
        end
      end else begin
        rc_d = rc_q + 5'd1;
      end

      if (rc_q == r9_q && !frame_end)
        ma_row_d = ma_nxt_d;

      if (frame_end) begin
        vcc_d    = 7'd0;
        rc_d     = 5'd0;
        adj_d    = 1'b0;
        adc_d    = 5'd0;
        ma_row_d = {r12_q, r13_q};
      end
    end

    if (hs_q) begin
      hsw_d = hsw_q + 4'd1;
      if (hsw_q + 4'd1 == r3_q[3:0])
        hs_d = 1'b0;
    end else if (hcc_d == r2_q &&
                 r3_q[3:0] != 4'd0) begin
      hs_d  = 1'b1;
      hsw_d = 4'd0;
    end

    if (line_end) begin
      if (vs_q) begin
        vsw_d = vsw_q + 4'd1;
        if ({1'b0, vsw_q} + 5'd1 == vs_width)
          vs_d = 1'b0;
      end else if (rc_d == 5'd0 &&
                   vcc_d == r7_q) begin
        vs_d  = 1'b1;
        vsw_d = 4'd0;
      end
    end
  end

  // Output values derived from the post-tick state
  always_comb begin
    de_d = (hcc_d < r1_q) &&
           (vcc_d < r6_q) && !adj_d;
    ma_d = ma_row_d + {6'd0, hcc_d};
  end

  assign HSYNC = hs_q;
  assign VSYNC = vs_q;
  assign DE    = de_q;
  assign MA    = ma_q;
  assign RA    = rc_q;

endmodule

// File: tb/tb_crtc_6845.sv
// Directed bench for crtc_6845.
// Default frame timing, addressing, adjust, sync widths, R0 wrap, reset.
module tb_crtc_6845;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        wr;
  logic        rs;
  logic [7:0]  di;
  logic        hs;
  logic        vs;
  logic        de;
  logic [13:0] ma;
  logic [4:0]  ra;

  int total;
  int passed;
  int fails;
  int t;

  crtc_6845 dut (
    .CLK     (clk),
    .RESET   (rst),
    .CE_CHAR (ce),
    .WR      (wr),
    .RS      (rs),
    .DI      (di),
    .HSYNC   (hs),
    .VSYNC   (vs),
    .DE      (de),
    .MA      (ma),
    .RA      (ra)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    ce = 1'b1;
    repeat (n) @(negedge clk);
    ce = 1'b0;
    t += n;
  endtask

  task automatic wr_reg(input logic [7:0] idx,
                        input logic [7:0] val);
    @(negedge clk);
    wr = 1'b1; rs = 1'b0; di = idx;
    @(negedge clk);
    rs = 1'b1; di = val;
    @(negedge clk);
    wr = 1'b0; rs = 1'b0;
  endtask

  int de_cnt, hs_cnt, vs_cnt, hs_rise;
  int hs_r0, hs_r1, vs_r0, vs_r1;
  int de_adj, f2;
  logic hs_p, vs_p;

  initial begin
    total = 0; passed = 0; fails = 0; t = 0;
    rst = 1'b1; ce = 1'b0; wr = 1'b0;
    rs = 1'b0; di = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_hs", 32'(hs), 0);
    chk("rst_vs", 32'(vs), 0);
    chk("rst_de", 32'(de), 0);
    chk("rst_ma", 32'(ma), 0);
    chk("rst_ra", 32'(ra), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("ce_gate_ma", 32'(ma), 0);

    // Frame 0 (defaults) and frame 1 with R5=2
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    hs_rise = 0; de_adj = 0;
    hs_r0 = -1; hs_r1 = -1;
    vs_r0 = -1; vs_r1 = -1;
    hs_p = 1'b0; vs_p = 1'b0;
    for (int i = 0; i < 40064; i++) begin
      step(1);
      if (t <= 19968) begin
        de_cnt += int'(de);
        hs_cnt += int'(hs);
        vs_cnt += int'(vs);
        if (hs && !hs_p) begin
          hs_rise++;
          if (hs_r0 < 0) hs_r0 = t;
          else if (hs_r1 < 0) hs_r1 = t;
        end
      end
      if (vs && !vs_p) begin
        if (vs_r0 < 0) vs_r0 = t;
        else if (vs_r1 < 0) vs_r1 = t;
      end
      hs_p = hs;
      vs_p = vs;
      if (t == 1) begin
        chk("t1_ma", 32'(ma), 1);
        chk("t1_de", 32'(de), 1);
      end
      if (t == 19968) begin
        chk("f1_ma", 32'(ma), 32'h3000);
        chk("f1_ra", 32'(ra), 0);
      end
      if (t == 20480)
        chk("row1_ma", 32'(ma), 32'h3028);
      if (t == 20677) begin
        chk("row1_l3_ma", 32'(ma), 32'h302D);
        chk("row1_l3_ra", 32'(ra), 3);
      end
      if (t == 32295) begin
        chk("row24_ma", 32'(ma), 32'h33E7);
        chk("row24_de", 32'(de), 1);
      end
      if (t == 32296)
        chk("de_hcc40", 32'(de), 0);
      if (t == 36000)
        wr_reg(8'd5, 8'd2);
      if (t >= 39936 && t < 40064)
        de_adj += int'(de);
      if (t == 39936)
        chk("adj_ra8", 32'(ra), 8);
      if (t == 40000)
        chk("adj_ra9", 32'(ra), 9);
    end
    chk("f0_de_cnt", 32'(de_cnt), 8000);
    chk("f0_hs_cnt", 32'(hs_cnt), 4368);
    chk("f0_hs_rises", 32'(hs_rise), 312);
    chk("hs_start", 32'(hs_r0), 46);
    chk("hs_period", 32'(hs_r1 - hs_r0), 64);
    chk("f0_vs_cnt", 32'(vs_cnt), 512);
    chk("vs_start", 32'(vs_r0), 15360);
    chk("vs_period", 32'(vs_r1 - vs_r0), 19968);
    chk("adj_de_low", 32'(de_adj), 0);
    chk("f2_ma", 32'(ma), 32'h3000);
    chk("f2_ra", 32'(ra), 0);
    chk("f2_de", 32'(de), 1);

    // R3=0x05: 5-char HSYNC, 16-line VSYNC
    f2 = t;
    wr_reg(8'd3, 8'h05);
    wr_reg(8'd7, 8'd1);
    hs_cnt = 0; vs_cnt = 0; vs_r0 = -1;
    vs_p = vs;
    for (int i = 0; i < 1600; i++) begin
      step(1);
      if (t < f2 + 64) hs_cnt += int'(hs);
      vs_cnt += int'(vs);
      if (vs && !vs_p && vs_r0 < 0) vs_r0 = t;
      vs_p = vs;
    end
    chk("r3_05_hs", 32'(hs_cnt), 5);
    chk("r3_05_vs", 32'(vs_cnt), 1024);
    chk("r3_05_vs0", 32'(vs_r0 - f2), 512);

    // R3=0x80: no HSYNC, 8-line VSYNC
    wr_reg(8'd3, 8'h80);
    wr_reg(8'd7, 8'd5);
    hs_cnt = 0; vs_cnt = 0; vs_r0 = -1;
    vs_p = vs;
    for (int i = 0; i < 1600; i++) begin
      step(1);
      hs_cnt += int'(hs);
      vs_cnt += int'(vs);
      if (vs && !vs_p && vs_r0 < 0) vs_r0 = t;
      vs_p = vs;
    end
    chk("r3_80_hs", 32'(hs_cnt), 0);
    chk("r3_80_vs", 32'(vs_cnt), 512);
    chk("r3_80_vs0", 32'(vs_r0 - f2), 2560);

    // Reach hcc=50, vcc=10 with defaults restored
    wr_reg(8'd3, 8'h8E);
    wr_reg(8'd7, 8'd30);
    step(1970);
    chk("pre_rst_ma", 32'(ma), 32'h31C2);
    chk("pre_rst_hs", 32'(hs), 1);
    chk("pre_rst_de", 32'(de), 0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_hs", 32'(hs), 0);
    chk("arst_ma", 32'(ma), 0);
    chk("arst_de", 32'(de), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    hs_cnt = 0; hs_r0 = -1; hs_p = hs;
    for (int i = 0; i < 64; i++) begin
      step(1);
      hs_cnt += int'(hs);
      if (hs && !hs_p && hs_r0 < 0) hs_r0 = t;
      hs_p = hs;
      if (t == 1)
        chk("rel_t1_ma", 32'(ma), 1);
    end
    chk("rel_hs_start", 32'(hs_r0), 46);
    chk("rel_hs_cnt", 32'(hs_cnt), 14);
    chk("rel_l1_ra", 32'(ra), 1);
    chk("rel_l1_ma", 32'(ma), 0);

    // R0=20 written at hcc=30 on the same edge as a tick
    step(30);
    chk("h30_ma", 32'(ma), 30);
    ce = 1'b1; wr = 1'b1; rs = 1'b1; di = 8'd20;
    @(negedge clk);
    ce = 1'b0; wr = 1'b0; rs = 1'b0;
    chk("r0_old_ma", 32'(ma), 31);
    step(224);
    chk("h255_ma", 32'(ma), 255);
    step(1);
    chk("wrap_ma", 32'(ma), 0);
    chk("wrap_ra", 32'(ra), 1);
    step(20);
    chk("h20_ma", 32'(ma), 20);
    chk("h20_ra", 32'(ra), 1);
    step(1);
    chk("l21_ma", 32'(ma), 0);
    chk("l21_ra", 32'(ra), 2);
    step(21);
    chk("l21b_ra", 32'(ra), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
